sys_ctrl_rx_decoder: RTL and testbench

Command-frame decoder on the receive side of the system controller. It consumes bytes from the UART RX deserializer, parses 2–4 byte command frames, and issues register-file write/read strobes and ALU operation requests. Its RF read strobe and ALU enable produce the `Rd_data_valid` / `ALU_OUT_valid` results that the TX-side controller serializes back into the TX FIFO.

---
 rtl/sys_ctrl_rx_decoder.sv | 190 +++++++++++++++++++
 tb/tb_sys_ctrl_rx_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_rx_decoder.sv
// sys_ctrl_rx_decoder
//   Receive-side command-frame decoder for the system controller. Parses
//   2-4 byte frames from the UART RX deserializer and issues register-file
//   write/read strobes and ALU operation requests.
//
//   Frames: AA addr data   (RF write)
//           BB addr        (RF read)
//           CC A B fun     (operands written to RF[0]/RF[1], then ALU)
//           DD fun         (ALU on current operands)
//
// Ports:
//   CLK, rst_n         clock, asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD received byte and its one-cycle valid pulse
//   ALU_OUT_valid      ALU result valid, closes an ALU operation
//   RF_Address/RF_WrEn/RF_RdEn/RF_WrData  register-file access
//   ALU_FUN/ALU_EN/CLK_GATE_EN            ALU request (level)
//   Frame_Err          one-cycle pulse on rejected byte or aborted frame
//
// Build option:
//   SYS_CTRL_RX_TIMEOUT_EN  enables an inter-byte timeout of TIMEOUT_CYCLES
//                           that aborts a partial frame.
module sys_ctrl_rx_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  ALU_OUT_valid,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic                  Frame_Err
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALUNO = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN, ALU_EXEC
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_lat_q;
  logic [ADDR_WIDTH-1:0]   rf_addr_q;
  logic                    rf_wr_q;
  logic                    rf_rd_q;
  logic [DATA_WIDTH-1:0]   rf_wdata_q;
  logic [FUN_WIDTH-1:0]    alu_fun_q;
  logic                    alu_en_q;
  logic                    gate_en_q;
  logic                    err_q;

`ifdef SYS_CTRL_RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timed_state;
  assign timed_state = (state_q != IDLE) && (state_q != ALU_EXEC);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_lat_q <= '0;
      rf_addr_q  <= '0;
      rf_wr_q    <= 1'b0;
      rf_rd_q    <= 1'b0;
      rf_wdata_q <= '0;
      alu_fun_q  <= '0;
      alu_en_q   <= 1'b0;
      gate_en_q  <= 1'b0;
      err_q      <= 1'b0;
`ifdef SYS_CTRL_RX_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      rf_wr_q <= 1'b0;
      rf_rd_q <= 1'b0;
      err_q   <= 1'b0;

`ifdef SYS_CTRL_RX_TIMEOUT_EN
      if (RX_D_VLD || !timed_state) tmo_cnt_q <= '0;
      else                          tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif

      case (state_q)
        IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_WR:    state_q <= WR_ADDR;
              CMD_RD:    state_q <= RD_ADDR;
              CMD_ALU:   state_q <= OPA;
              CMD_ALUNO: state_q <= FUN;
              default:   err_q   <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_lat_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            rf_wr_q    <= 1'b1;
            rf_addr_q  <= addr_lat_q;
            rf_wdata_q <= RX_P_DATA;
            state_q    <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            rf_rd_q   <= 1'b1;
            rf_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q   <= IDLE;
          end
        end
        OPA: begin
          if (RX_D_VLD) begin
            rf_wr_q    <= 1'b1;
            rf_addr_q  <= '0;
            rf_wdata_q <= RX_P_DATA;
            state_q    <= OPB;
          end
        end
        OPB: begin
          if (RX_D_VLD) begin
            rf_wr_q    <= 1'b1;
            rf_addr_q  <= ADDR_WIDTH'(1);
            rf_wdata_q <= RX_P_DATA;
            state_q    <= FUN;
          end
        end
        FUN: begin
          if (RX_D_VLD) begin
            alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
            alu_en_q  <= 1'b1;
            gate_en_q <= 1'b1;
            state_q   <= ALU_EXEC;
          end
        end
        ALU_EXEC: begin
          // Bytes are not accepted while the ALU is busy; a byte arriving
          // together with ALU_OUT_valid is still dropped.
          if (RX_D_VLD) err_q <= 1'b1;
          if (ALU_OUT_valid) begin
            alu_en_q  <= 1'b0;
            gate_en_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef SYS_CTRL_RX_TIMEOUT_EN
      // Overrides the case above only on idle cycles, so no strobe can be
      // issued in the cycle a frame is abandoned.
      if (timed_state && !RX_D_VLD &&
          tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        err_q     <= 1'b1;
        state_q   <= IDLE;
        tmo_cnt_q <= '0;
      end
`endif
    end
  end

  assign RF_Address  = rf_addr_q;
  assign RF_WrEn     = rf_wr_q;
  assign RF_RdEn     = rf_rd_q;
  assign RF_WrData   = rf_wdata_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = gate_en_q;
  assign Frame_Err   = err_q;

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
module tb_sys_ctrl_rx_decoder;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       ALU_OUT_valid;
  logic [3:0] RF_Address;
  logic       RF_WrEn;
  logic       RF_RdEn;
  logic [7:0] RF_WrData;
  logic [3:0] ALU_FUN;
  logic       ALU_EN;
  logic       CLK_GATE_EN;
  logic       Frame_Err;

  always #5 CLK = ~CLK;

  sys_ctrl_rx_decoder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .FUN_WIDTH     (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .ALU_OUT_valid(ALU_OUT_valid),
    .RF_Address   (RF_Address),
    .RF_WrEn      (RF_WrEn),
    .RF_RdEn      (RF_RdEn),
    .RF_WrData    (RF_WrData),
    .ALU_FUN      (ALU_FUN),
    .ALU_EN       (ALU_EN),
    .CLK_GATE_EN  (CLK_GATE_EN),
    .Frame_Err    (Frame_Err)
  );

  // Event kinds observed on the outputs
  localparam int EV_WR  = 0;  // RF_WrEn pulse: addr, data
  localparam int EV_RD  = 1;  // RF_RdEn pulse: addr, held data
  localparam int EV_ERR = 2;  // Frame_Err pulse: held addr, held data
  localparam int EV_ON  = 3;  // ALU_EN rise: data = {gate,3'b0,fun}
  localparam int EV_OFF = 4;  // ALU_EN fall: data = {gate,3'b0,fun}

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  logic prev_en = 1'b0;

  task automatic expect_ev(input int k, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic score(input int k, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, expected no event",
               k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.addr == a && e.data == d) passes++;
      else
        $display("FAIL event: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, expv);
  endtask

  // Monitor: sample outputs on the falling edge and score every event
  always @(negedge CLK) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (RF_WrEn)   score(EV_WR,  RF_Address, RF_WrData);
      if (RF_RdEn)   score(EV_RD,  RF_Address, RF_WrData);
      if (Frame_Err) score(EV_ERR, RF_Address, RF_WrData);
      if (ALU_EN && !prev_en) score(EV_ON,  4'h0, {CLK_GATE_EN, 3'b000, ALU_FUN});
      if (!ALU_EN && prev_en) score(EV_OFF, 4'h0, {CLK_GATE_EN, 3'b000, ALU_FUN});
      prev_en = ALU_EN;
    end
  end

  // Callers start on a falling edge; consecutive calls give back-to-back bytes
  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic alu_done();
    ALU_OUT_valid = 1'b1;
    @(negedge CLK);
    ALU_OUT_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b1;
    RX_P_DATA     = 8'h00;
    RX_D_VLD      = 1'b0;
    ALU_OUT_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_outputs", 32'({RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN,
                              ALU_EN, CLK_GATE_EN, Frame_Err}), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // RF write
    send(8'hAA); send(8'h05);
    expect_ev(EV_WR, 4'h5, 8'h3C);
    send(8'h3C);
    idle(2);

    // RF read, upper address bits ignored; write data held
    send(8'hBB);
    expect_ev(EV_RD, 4'h7, 8'h3C);
    send(8'h17);
    idle(2);

    // ALU with operands, back-to-back bytes
    send(8'hCC);
    expect_ev(EV_WR, 4'h0, 8'h10);
    send(8'h10);
    expect_ev(EV_WR, 4'h1, 8'h20);
    send(8'h20);
    expect_ev(EV_ON, 4'h0, 8'h82);
    send(8'h02);
    idle(3);
    chk("alu_en_hold1", 32'({ALU_EN, CLK_GATE_EN}), 32'h3);
    expect_ev(EV_OFF, 4'h0, 8'h02);
    alu_done();
    idle(2);

    // ALU without operands, byte dropped during execution
    send(8'hDD);
    expect_ev(EV_ON, 4'h0, 8'h83);
    send(8'h03);
    idle(2);
    expect_ev(EV_ERR, 4'h1, 8'h20);
    send(8'h44);
    idle(2);
    chk("alu_en_hold2", 32'({ALU_EN, CLK_GATE_EN, 4'(ALU_FUN)}), 32'h33);
    expect_ev(EV_OFF, 4'h0, 8'h03);
    alu_done();
    send(8'hAA); send(8'h01);
    expect_ev(EV_WR, 4'h1, 8'hFF);
    send(8'hFF);
    idle(2);

    // Byte arriving in the same cycle as ALU_OUT_valid is dropped
    send(8'hDD);
    expect_ev(EV_ON, 4'h0, 8'h89);
    send(8'h09);
    idle(1);
    expect_ev(EV_ERR, 4'h1, 8'hFF);
    expect_ev(EV_OFF, 4'h0, 8'h09);
    RX_P_DATA     = 8'h77;
    RX_D_VLD      = 1'b1;
    ALU_OUT_valid = 1'b1;
    @(negedge CLK);
    RX_D_VLD      = 1'b0;
    ALU_OUT_valid = 1'b0;
    idle(2);

    // Unknown command byte
    expect_ev(EV_ERR, 4'h1, 8'hFF);
    send(8'h55);
    idle(2);

    // Command bytes mid-frame are payload
    send(8'hAA); send(8'hBB);
    expect_ev(EV_WR, 4'hB, 8'hCC);
    send(8'hCC);
    idle(2);

    // Asynchronous reset mid-frame
    send(8'hAA); send(8'h05);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN,
                                    ALU_EN, CLK_GATE_EN, Frame_Err}), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(8'hBB);
    expect_ev(EV_RD, 4'h2, 8'h00);
    send(8'h02);
    idle(2);

    // Partial frame left idle for longer than the timeout window
`ifdef SYS_CTRL_RX_TIMEOUT_EN
    expect_ev(EV_ERR, 4'h2, 8'h00);
    send(8'hAA); send(8'h05);
    idle(20);
    expect_ev(EV_ERR, 4'h2, 8'h00);
    send(8'h3C);
`else
    send(8'hAA); send(8'h05);
    idle(20);
    expect_ev(EV_WR, 4'h5, 8'h3C);
    send(8'h3C);
`endif
    idle(5);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
